// File: rtl/tensor_core_pkg.sv
// Shared opcode/state types and default sizing for the tensor-core sequencer slice.
package tensor_core_pkg;

  localparam int NUMBER_OF_REGISTERS_DEFAULT = 32;
  localparam int DATA_WIDTH_DEFAULT          = 4;
  localparam int COMPUTE_TIMEOUT_DEFAULT     = 255;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_COMPUTE = 2'd1,
    OP_READ    = 2'd2,
    OP_CLEAR   = 2'd3
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE_START,
    ST_COMPUTE_WAIT,
    ST_WRITEBACK,
    ST_READ_FETCH,
    ST_READ_HOLD,
    ST_CLEAR
  } sequencer_state_t;

endpackage

// File: rtl/tensor_core_address_walker.sv
// Register pointer and remaining-element count shared by LOAD and READ streaming.
// Pointer wraps modulo the register count; last flags the final element of a burst.
module tensor_core_address_walker #(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int AW = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic          clock_in,
  input  logic          reset_in,
  input  logic          load,
  input  logic [AW-1:0] base_address,
  input  logic [AW:0]   count,
  input  logic          step,
  output logic [AW-1:0] pointer,
  output logic          last
);

  logic [AW:0] remaining;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      pointer   <= '0;
      remaining <= '0;
    end else if (load) begin
      pointer   <= base_address;
      remaining <= count;
    end else if (step) begin
      // Explicit wrap keeps non-power-of-two register files correct.
      if (pointer == AW'(NUMBER_OF_REGISTERS - 1))
        pointer <= '0;
      else
        pointer <= pointer + AW'(1);
      remaining <= remaining - (AW+1)'(1);
    end
  end

  assign last = (remaining == (AW+1)'(1));

endmodule

// File: rtl/tensor_core_sequencer.sv
// Command sequencer between host link and register file / tensor core; one command at a time.
// LOAD writes in the handshake cycle, READ yields one element per 2 cycles, holding data until consumed.
module tensor_core_sequencer
  import tensor_core_pkg::*;
#(
  parameter int NUMBER_OF_REGISTERS = NUMBER_OF_REGISTERS_DEFAULT,
  parameter int DATA_WIDTH          = DATA_WIDTH_DEFAULT,
  parameter int COMPUTE_TIMEOUT     = COMPUTE_TIMEOUT_DEFAULT,
  localparam int AW = $clog2(NUMBER_OF_REGISTERS),
  localparam int TW = $clog2(COMPUTE_TIMEOUT + 1)
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         cmd_valid_in,
  output logic                         cmd_ready_out,
  input  logic [1:0]                   cmd_opcode_in,
  input  logic [AW-1:0]                cmd_base_address_in,
  input  logic [AW:0]                  cmd_count_in,
  input  logic                         data_in_valid_in,
  output logic                         data_in_ready_out,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         data_out_valid_out,
  input  logic                         data_out_ready_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         rf_write_enable_out,
  output logic [AW-1:0]                rf_write_address_out,
  output logic signed [DATA_WIDTH-1:0] rf_write_data_out,
  output logic [AW-1:0]                rf_read_address_out,
  input  logic signed [DATA_WIDTH-1:0] rf_read_data_in,
  output logic                         rf_bulk_write_enable_out,
  output logic                         rf_clear_out,
  output logic                         tc_start_out,
  input  logic                         tc_done_in,
  output logic                         busy_out,
  output logic                         error_out
);

  sequencer_state_t state;
  opcode_t          opcode;
  logic [TW-1:0]    timer;
  logic [AW-1:0]    ptr;
  logic             last;
  logic             accept;
  logic             load_hs;
  logic             read_hs;
  logic             bad_count;

  assign opcode    = opcode_t'(cmd_opcode_in);
  assign accept    = cmd_valid_in && cmd_ready_out;
  assign load_hs   = data_in_ready_out && data_in_valid_in;
  assign read_hs   = (state == ST_READ_HOLD) && data_out_ready_in;
  assign bad_count = cmd_count_in > (AW+1)'(NUMBER_OF_REGISTERS);

  tensor_core_address_walker #(
    .NUMBER_OF_REGISTERS(NUMBER_OF_REGISTERS),
    .AW                 (AW)
  ) u_walker (
    .clock_in    (clock_in),
    .reset_in    (reset_in),
    .load        (accept),
    .base_address(cmd_base_address_in),
    .count       (cmd_count_in),
    .step        (load_hs || read_hs),
    .pointer     (ptr),
    .last        (last)
  );

  // Strobes decode straight from state so reset silences them immediately.
  assign cmd_ready_out            = (state == ST_IDLE);
  assign busy_out                 = (state != ST_IDLE);
  assign data_in_ready_out        = (state == ST_LOAD);
  assign tc_start_out             = (state == ST_COMPUTE_START);
  assign rf_bulk_write_enable_out = (state == ST_WRITEBACK);
  assign rf_clear_out             = (state == ST_CLEAR);
  assign rf_write_enable_out      = load_hs;
  assign rf_write_address_out     = load_hs ? ptr : '0;
  assign rf_write_data_out        = load_hs ? data_in : '0;
  assign rf_read_address_out      = ptr;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state              <= ST_IDLE;
      timer              <= '0;
      error_out          <= 1'b0;
      data_out           <= '0;
      data_out_valid_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            error_out <= 1'b0;
            case (opcode)
              OP_COMPUTE: state <= ST_COMPUTE_START;
              OP_CLEAR:   state <= ST_CLEAR;
              default: begin
                if (bad_count)
                  error_out <= 1'b1;
                else if (cmd_count_in != '0)
                  state <= (opcode == OP_LOAD) ? ST_LOAD : ST_READ_FETCH;
              end
            endcase
          end
        end
        ST_LOAD: begin
          if (load_hs && last)
            state <= ST_IDLE;
        end
        ST_COMPUTE_START: begin
          timer <= '0;
          state <= ST_COMPUTE_WAIT;
        end
        ST_COMPUTE_WAIT: begin
          if (tc_done_in) begin
            state <= ST_WRITEBACK;
          end else if (timer == TW'(COMPUTE_TIMEOUT - 1)) begin
            error_out <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_READ_FETCH: begin
          data_out           <= rf_read_data_in;
          data_out_valid_out <= 1'b1;
          state              <= ST_READ_HOLD;
        end
        ST_READ_HOLD: begin
          // Valid drops on every handshake so a fetch cycle never re-presents stale data.
          if (read_hs) begin
            data_out_valid_out <= 1'b0;
            state              <= last ? ST_IDLE : ST_READ_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Self-checking bench: table vectors, directed corner sequences and randomized LOAD/READ/COMPUTE traffic.
module tb_tensor_core_sequencer;
  import tensor_core_pkg::*;

  localparam int N   = 32;
  localparam int AW  = 5;
  localparam int DW  = 4;
  localparam int TMO = 255;

  logic          clock_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          cmd_valid_in, cmd_ready_out;
  logic [1:0]    cmd_opcode_in;
  logic [AW-1:0] cmd_base_address_in;
  logic [AW:0]   cmd_count_in;
  logic          data_in_valid_in, data_in_ready_out;
  logic [DW-1:0] data_in;
  logic          data_out_valid_out, data_out_ready_in;
  logic [DW-1:0] data_out;
  logic          rf_write_enable_out;
  logic [AW-1:0] rf_write_address_out, rf_read_address_out;
  logic [DW-1:0] rf_write_data_out, rf_read_data_in;
  logic          rf_bulk_write_enable_out, rf_clear_out, tc_start_out, tc_done_in;
  logic          busy_out, error_out;

  always #5 clock_in = ~clock_in;

  tensor_core_sequencer dut (
    .clock_in                (clock_in),
    .reset_in                (reset_in),
    .cmd_valid_in            (cmd_valid_in),
    .cmd_ready_out           (cmd_ready_out),
    .cmd_opcode_in           (cmd_opcode_in),
    .cmd_base_address_in     (cmd_base_address_in),
    .cmd_count_in            (cmd_count_in),
    .data_in_valid_in        (data_in_valid_in),
    .data_in_ready_out       (data_in_ready_out),
    .data_in                 (data_in),
    .data_out_valid_out      (data_out_valid_out),
    .data_out_ready_in       (data_out_ready_in),
    .data_out                (data_out),
    .rf_write_enable_out     (rf_write_enable_out),
    .rf_write_address_out    (rf_write_address_out),
    .rf_write_data_out       (rf_write_data_out),
    .rf_read_address_out     (rf_read_address_out),
    .rf_read_data_in         (rf_read_data_in),
    .rf_bulk_write_enable_out(rf_bulk_write_enable_out),
    .rf_clear_out            (rf_clear_out),
    .tc_start_out            (tc_start_out),
    .tc_done_in              (tc_done_in),
    .busy_out                (busy_out),
    .error_out               (error_out)
  );

  // Register file environment: synchronous writes/clear, combinational read.
  logic [DW-1:0] rf_mem [N] = '{default: '0};
  assign rf_read_data_in = rf_mem[rf_read_address_out];
  always @(posedge clock_in) begin
    if (rf_clear_out) begin
      for (int i = 0; i < N; i++) rf_mem[i] <= '0;
    end else if (rf_write_enable_out) begin
      rf_mem[rf_write_address_out] <= rf_write_data_out;
    end
  end

  // Reference contents expected in the register file, updated from command semantics.
  logic [DW-1:0] ref_mem [N] = '{default: '0};

  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  int cyc = 0, bulk_cnt = 0, clr_cnt = 0, start_cnt = 0, excl_viol = 0;
  int start_cyc = 0, bulk_cyc = 0;

  always @(negedge clock_in) begin
    cyc <= cyc + 1;
    if (rf_write_enable_out) begin
      wr_addr_q.push_back(rf_write_address_out);
      wr_data_q.push_back(rf_write_data_out);
    end
    if (rf_bulk_write_enable_out) begin
      bulk_cnt <= bulk_cnt + 1;
      bulk_cyc <= cyc;
    end
    if (tc_start_out) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (rf_clear_out) clr_cnt <= clr_cnt + 1;
    if (int'(rf_write_enable_out) + int'(rf_bulk_write_enable_out) + int'(rf_clear_out) > 1)
      excl_viol <= excl_viol + 1;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic issue(input opcode_t op, input int base, input int count);
    bit ok;
    ok = 1'b0;
    cmd_valid_in        = 1'b1;
    cmd_opcode_in       = op;
    cmd_base_address_in = AW'(base);
    cmd_count_in        = (AW+1)'(count);
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock_in);
      ok = cmd_ready_out;
      tick();
    end
    cmd_valid_in = 1'b0;
    check("cmd_accept", ok, 1);
  endtask

  task automatic send_data(input logic [DW-1:0] vals [$], input bit gaps);
    bit done;
    foreach (vals[k]) begin
      done = 1'b0;
      if (gaps) begin
        data_in_valid_in = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      data_in_valid_in = 1'b1;
      data_in          = vals[k];
      for (int t = 0; t < 20 && !done; t++) begin
        @(negedge clock_in);
        done = data_in_ready_out;
        tick();
      end
      check("load_elem_accept", done, 1);
    end
    data_in_valid_in = 1'b0;
    data_in          = '0;
  endtask

  task automatic recv(input int n, input bit throttle, output logic [DW-1:0] got [$]);
    got = {};
    data_out_ready_in = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int t = 0; t < 40 * n + 40 && got.size() < n; t++) begin
      @(negedge clock_in);
      if (data_out_valid_out && data_out_ready_in) got.push_back(data_out);
      tick();
      data_out_ready_in = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    data_out_ready_in = 1'b0;
  endtask

  task automatic do_load(input int base, input int count, input logic [DW-1:0] vals [$], input bit gaps);
    int w0, nexp;
    bit bad;
    w0   = wr_addr_q.size();
    bad  = (count > N);
    nexp = bad ? 0 : count;
    issue(OP_LOAD, base, count);
    if (nexp > 0) send_data(vals, gaps);
    @(negedge clock_in);
    check("load_error", error_out, bad);
    check("load_busy_after", busy_out, 0);
    tick();
    check("load_write_count", wr_addr_q.size() - w0, nexp);
    for (int i = 0; i < nexp && w0 + i < wr_addr_q.size(); i++) begin
      check($sformatf("load_addr[%0d]", i), wr_addr_q[w0+i], (base + i) % N);
      check($sformatf("load_data[%0d]", i), wr_data_q[w0+i], vals[i]);
    end
    for (int i = 0; i < nexp; i++) ref_mem[(base + i) % N] = vals[i];
  endtask

  task automatic do_read(input int base, input int count, input bit throttle);
    logic [DW-1:0] got [$];
    int n;
    bit bad;
    bad = (count > N);
    n   = bad ? 0 : count;
    got = {};
    issue(OP_READ, base, count);
    if (n > 0) recv(n, throttle, got);
    @(negedge clock_in);
    check("read_error", error_out, bad);
    check("read_busy_after", busy_out, 0);
    check("read_valid_after", data_out_valid_out, 0);
    tick();
    check("read_count", got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++)
      check($sformatf("read_data[%0d]", i), got[i], ref_mem[(base + i) % N]);
  endtask

  task automatic do_compute(input int d);
    int b0, s0;
    bit seen;
    b0 = bulk_cnt;
    s0 = start_cnt;
    seen = 1'b0;
    tc_done_in = 1'b0;
    issue(OP_COMPUTE, 0, 0);
    repeat (d) tick();
    tc_done_in = 1'b1;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clock_in);
      seen = rf_bulk_write_enable_out;
      tick();
    end
    tc_done_in = 1'b0;
    check("compute_bulk_seen", seen, 1);
    @(negedge clock_in);
    check("compute_error", error_out, 0);
    check("compute_busy_after", busy_out, 0);
    tick();
    check("compute_start_pulses", start_cnt - s0, 1);
    check("compute_bulk_pulses", bulk_cnt - b0, 1);
    // Done raised during the start cycle is ignored, so it only counts from the next cycle.
    check($sformatf("compute_done_to_bulk_d%0d", d), bulk_cyc - start_cyc, (d == 0) ? 2 : d + 1);
  endtask

  task automatic do_timeout();
    int b0, busy_n;
    bit err_seen, busy_at_err;
    b0 = bulk_cnt;
    busy_n = 0;
    err_seen = 1'b0;
    busy_at_err = 1'b1;
    tc_done_in = 1'b0;
    issue(OP_COMPUTE, 0, 0);
    for (int t = 0; t < 400 && !err_seen; t++) begin
      @(negedge clock_in);
      if (error_out) begin
        err_seen = 1'b1;
        busy_at_err = busy_out;
      end else if (busy_out) begin
        busy_n++;
      end
      tick();
    end
    check("timeout_error", err_seen, 1);
    check("timeout_busy_at_error", busy_at_err, 0);
    check("timeout_wait_cycles", busy_n - 1, TMO);
    check("timeout_no_bulk", bulk_cnt - b0, 0);
    issue(OP_LOAD, 0, 0);
    @(negedge clock_in);
    check("timeout_error_cleared", error_out, 0);
    tick();
  endtask

  task automatic do_stall_read();
    logic [DW-1:0] v [$];
    logic [DW-1:0] got [$];
    logic [DW-1:0] d0;
    bit seen, stable;
    v = {};
    v.push_back(4'd4); v.push_back(4'hF); v.push_back(4'd6);
    do_load(7, 3, v, 1'b0);
    seen = 1'b0;
    stable = 1'b1;
    d0 = '0;
    data_out_ready_in = 1'b0;
    issue(OP_READ, 7, 3);
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clock_in);
      if (data_out_valid_out) begin
        seen = 1'b1;
        d0 = data_out;
      end
      tick();
    end
    check("stall_valid_seen", seen, 1);
    check("stall_first_data", d0, ref_mem[7]);
    repeat (10) begin
      @(negedge clock_in);
      if (!data_out_valid_out || data_out !== d0) stable = 1'b0;
      tick();
    end
    check("stall_held_stable", stable, 1);
    recv(3, 1'b0, got);
    check("stall_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++)
      check($sformatf("stall_data[%0d]", i), got[i], ref_mem[7 + i]);
    @(negedge clock_in);
    check("stall_busy_after", busy_out, 0);
    tick();
  endtask

  task automatic do_reset_mid_load();
    logic [DW-1:0] v [$];
    int w0, c0;
    v = {};
    v.push_back(4'd5); v.push_back(4'hA);
    w0 = wr_addr_q.size();
    issue(OP_LOAD, 10, 6);
    send_data(v, 1'b0);
    data_in_valid_in = 1'b1;
    data_in = 4'd7;
    reset_in = 1'b0;
    #1;
    check("rst_mid_write_en", rf_write_enable_out, 0);
    check("rst_mid_outputs", {busy_out, data_in_ready_out, error_out, data_out_valid_out,
                              tc_start_out, rf_bulk_write_enable_out, rf_clear_out}, 0);
    check("rst_mid_cmd_ready", cmd_ready_out, 1);
    data_in_valid_in = 1'b0;
    data_in = '0;
    tick(); tick();
    reset_in = 1'b1;
    tick();
    check("rst_mid_write_count", wr_addr_q.size() - w0, 2);
    check("rst_mid_kept0", rf_mem[10], 5);
    check("rst_mid_kept1", rf_mem[11], 4'hA);
    check("rst_mid_untouched", rf_mem[12], ref_mem[12]);
    ref_mem[10] = 4'd5;
    ref_mem[11] = 4'hA;
    c0 = clr_cnt;
    issue(OP_CLEAR, 0, 0);
    repeat (3) tick();
    check("rst_mid_clear_pulses", clr_cnt - c0, 1);
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
  endtask

  typedef struct {
    opcode_t op;
    int      base;
    int      count;
    bit      exp_err;
    bit      exp_busy;
    int      exp_clr;
  } vec_t;

  task automatic run_table();
    vec_t vecs [7];
    int w0, c0;
    vecs[0] = '{OP_LOAD,  5,  33, 1'b1, 1'b0, 0};
    vecs[1] = '{OP_LOAD,  5,  0,  1'b0, 1'b0, 0};
    vecs[2] = '{OP_READ,  0,  40, 1'b1, 1'b0, 0};
    vecs[3] = '{OP_CLEAR, 0,  0,  1'b0, 1'b1, 1};
    vecs[4] = '{OP_READ,  31, 0,  1'b0, 1'b0, 0};
    vecs[5] = '{OP_LOAD,  0,  63, 1'b1, 1'b0, 0};
    vecs[6] = '{OP_READ,  3,  0,  1'b0, 1'b0, 0};
    for (int i = 0; i < 7; i++) begin
      w0 = wr_addr_q.size();
      c0 = clr_cnt;
      issue(vecs[i].op, vecs[i].base, vecs[i].count);
      @(negedge clock_in);
      check($sformatf("vec%0d_error", i), error_out, vecs[i].exp_err);
      check($sformatf("vec%0d_busy", i), busy_out, vecs[i].exp_busy);
      check($sformatf("vec%0d_cmd_ready", i), cmd_ready_out, !vecs[i].exp_busy);
      repeat (3) tick();
      check($sformatf("vec%0d_writes", i), wr_addr_q.size() - w0, 0);
      check($sformatf("vec%0d_clears", i), clr_cnt - c0, vecs[i].exp_clr);
    end
  endtask

  task automatic do_random(input int iters);
    logic [DW-1:0] v [$];
    int sel, base, count, pick;
    for (int it = 0; it < iters; it++) begin
      sel  = $urandom_range(0, 9);
      base = $urandom_range(0, N - 1);
      if ($urandom_range(0, 7) == 0) begin
        pick  = $urandom_range(0, 2);
        count = (pick == 0) ? 0 : (pick == 1) ? N : N + 1 + $urandom_range(0, 30);
      end else begin
        count = $urandom_range(1, 8);
      end
      if (sel < 4) begin
        v = {};
        for (int i = 0; i < count && count <= N; i++) v.push_back(DW'($urandom_range(0, 15)));
        do_load(base, count, v, 1'b1);
      end else if (sel < 8) begin
        do_read(base, count, 1'b1);
      end else begin
        do_compute($urandom_range(0, 8));
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] v [$];
    int t1 [4] = '{1, -2, 3, -8};
    cmd_valid_in = 1'b0; cmd_opcode_in = '0; cmd_base_address_in = '0; cmd_count_in = '0;
    data_in_valid_in = 1'b0; data_in = '0; data_out_ready_in = 1'b0; tc_done_in = 1'b0;
    #2 reset_in = 1'b0;
    repeat (2) @(posedge clock_in);
    #1;
    check("reset_cmd_ready", cmd_ready_out, 1);
    check("reset_busy", busy_out, 0);
    check("reset_error", error_out, 0);
    check("reset_data_out", {data_out_valid_out, data_out}, 0);
    check("reset_strobes", {rf_write_enable_out, rf_bulk_write_enable_out, rf_clear_out,
                            tc_start_out, data_in_ready_out}, 0);
    check("reset_read_addr", rf_read_address_out, 0);
    reset_in = 1'b1;
    tick();

    run_table();

    v = {};
    for (int i = 0; i < 4; i++) v.push_back(DW'(t1[i]));
    do_load(30, 4, v, 1'b0);
    do_read(30, 4, 1'b0);

    do_compute(5);
    do_compute(0);
    do_timeout();
    do_stall_read();
    do_reset_mid_load();
    do_random(40);

    check("exclusive_strobes", excl_viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
